// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle Hack-style CPU: FSM states,
// instruction field positions and flag bit indices.
package cpu_mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR,
        HALT
    } state_e;

    localparam int unsigned A_BIT = 12;
    localparam int unsigned C_LSB = 6;
    localparam int unsigned D_LSB = 3;
    localparam int unsigned J_LSB = 0;

    localparam int unsigned NG = 2;
    localparam int unsigned ZR = 1;
    localparam int unsigned PS = 0;

    localparam logic [2:0] FLAG_RESET = 3'b010;

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational Hack ALU of parametrised width; arithmetic wraps modulo 2^DATA_W.
module alu_w #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        c,
    output logic [DATA_W-1:0] out,
    output logic              ng,
    output logic              zr
);

    logic [DATA_W-1:0] xs;
    logic [DATA_W-1:0] ys;
    logic [DATA_W-1:0] raw;

    // c = {zx, nx, zy, ny, f, no}
    always_comb begin
        xs = c[5] ? '0 : x;
        if (c[4]) xs = ~xs;
        ys = c[3] ? '0 : y;
        if (c[2]) ys = ~ys;
        raw = c[1] ? (xs + ys) : (xs & ys);
        out = c[0] ? ~raw : raw;
    end

    assign ng = out[DATA_W-1];
    assign zr = (out == '0);

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle Hack-style CPU with valid/ack handshakes to instruction and data memory.
// Control fields always live in instr[15:0]; DATA_W only widens the datapath.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] inM,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic              wrtM,
    output logic [DATA_W-1:0] outM,
    output logic [ADDR_W-1:0] addrM,
    output logic [2:0]        flagM,
    output logic              halted
);

    state_e state;
    state_e stateNext;

    logic [DATA_W-1:0] instrReg;
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regD;
    logic [DATA_W-1:0] mLatch;
    logic [DATA_W-1:0] aluY;
    logic [DATA_W-1:0] aluOut;
    logic              aluNg;
    logic              aluZr;
    logic [2:0]        aluFlags;

    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] pcPending;
    logic [ADDR_W-1:0] pcInc;
    logic [ADDR_W-1:0] jumpTarget;
    logic [ADDR_W-1:0] pcNext;

    logic       isCInstr;
    logic       aBit;
    logic [5:0] cBits;
    logic [2:0] dBits;
    logic [2:0] jBits;
    logic       jumpTaken;
    logic       haltHit;

    assign isCInstr = instrReg[DATA_W-1];
    assign aBit     = instrReg[A_BIT];
    assign cBits    = instrReg[C_LSB +: 6];
    assign dBits    = instrReg[D_LSB +: 3];
    assign jBits    = instrReg[J_LSB +: 3];

    assign aluY = aBit ? mLatch : regA;

    alu_w #(.DATA_W(DATA_W)) uAlu (
        .x   (regD),
        .y   (aluY),
        .c   (cBits),
        .out (aluOut),
        .ng  (aluNg),
        .zr  (aluZr)
    );

    always_comb begin
        aluFlags     = '0;
        aluFlags[NG] = aluNg;
        aluFlags[ZR] = aluZr;
        aluFlags[PS] = ~aluNg & ~aluZr;
    end

    // Jump target and write address both come from A as it was before EXEC.
    assign jumpTarget = regA[ADDR_W-1:0];
    assign pcInc      = pc + 1'b1;
    assign jumpTaken  = |(jBits & aluFlags);
    assign pcNext     = jumpTaken ? jumpTarget : pcInc;
    assign haltHit    = jumpTaken && (jumpTarget == pc) && (dBits == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        mem_rd    = 1'b0;
        wrtM      = 1'b0;
        halted    = 1'b0;
        addrM     = regA[ADDR_W-1:0];
        unique case (state)
            FETCH: begin
                if (instr_valid) stateNext = DECODE;
            end
            DECODE: begin
                if (!isCInstr)  stateNext = FETCH;
                else if (aBit)  stateNext = MEM_RD;
                else            stateNext = EXEC;
            end
            MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ack) stateNext = EXEC;
            end
            EXEC: begin
                if (haltHit)       stateNext = HALT;
                else if (dBits[0]) stateNext = MEM_WR;
                else               stateNext = FETCH;
            end
            MEM_WR: begin
                wrtM  = 1'b1;
                addrM = wrAddr;
                if (mem_ack) stateNext = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            regA      <= '0;
            regD      <= '0;
            outM      <= '0;
            flagM     <= FLAG_RESET;
            instrReg  <= '0;
            mLatch    <= '0;
            wrAddr    <= '0;
            pcPending <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (instr_valid) instrReg <= instr;
                end
                DECODE: begin
                    if (!isCInstr) begin
                        regA <= {1'b0, instrReg[DATA_W-2:0]};
                        pc   <= pcInc;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) mLatch <= inM;
                end
                EXEC: begin
                    outM   <= aluOut;
                    flagM  <= aluFlags;
                    wrAddr <= regA[ADDR_W-1:0];
                    if (dBits[2]) regA <= aluOut;
                    if (dBits[1]) regD <= aluOut;
                    // A memory write defers the pc update until its ack arrives.
                    if (dBits[0]) pcPending <= pcNext;
                    else          pc        <= pcNext;
                end
                MEM_WR: begin
                    if (mem_ack) pc <= pcPending;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Randomised self-checking bench for cpu_mc: an instruction-level Hack model
// predicts write/read/pc traces, final state and zero-wait cycle counts.
module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [14:0] pc;
    logic [15:0] inM;
    logic        mem_ack;
    logic        mem_rd;
    logic        wrtM;
    logic [15:0] outM;
    logic [14:0] addrM;
    logic [2:0]  flagM;
    logic        halted;

    always #5 clk = ~clk;

    cpu_mc #(.DATA_W(16), .ADDR_W(15)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .inM(inM), .mem_ack(mem_ack), .mem_rd(mem_rd), .wrtM(wrtM), .outM(outM),
        .addrM(addrM), .flagM(flagM), .halted(halted)
    );

    // Wide instance for the 24/20-bit wrap and halt cases.
    logic        reset24;
    logic        tailJump24;
    logic [23:0] instr24;
    logic [19:0] pc24;
    logic        memRd24;
    logic        wrtM24;
    logic [23:0] outM24;
    logic [19:0] addrM24;
    logic [2:0]  flagM24;
    logic        halted24;

    cpu_mc #(.DATA_W(24), .ADDR_W(20)) dut24 (
        .clk(clk), .reset(reset24), .instr(instr24), .instr_valid(1'b1), .pc(pc24),
        .inM(24'h0), .mem_ack(1'b0), .mem_rd(memRd24), .wrtM(wrtM24), .outM(outM24),
        .addrM(addrM24), .flagM(flagM24), .halted(halted24)
    );

    always_comb begin
        case (pc24)
            20'h00000: instr24 = 24'h0FFFFF;
            20'h00001: instr24 = 24'hFFEA87;
            20'hFFFFF: instr24 = tailJump24 ? 24'hFFEA87 : 24'hFFEC10;
            default:   instr24 = 24'h000000;
        endcase
    end

    int unsigned nTests = 0;
    int unsigned nFail  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] rom [0:255];
    logic [15:0] ram  [logic [14:0]];
    logic [15:0] mMem [logic [14:0]];
    int unsigned wp;

    int          delayMode = 0;   // 0 zero-wait, 1 random waits, 2 fixed 2-cycle data waits
    bit          withholdWr = 1'b0;
    bit          ackIdle = 1'b0;
    int unsigned cyc = 0;
    int unsigned haltCycle = 0;
    logic [14:0] lastPc = '0;

    logic [30:0] obsW[$], expW[$];
    logic [14:0] obsR[$], expR[$], obsPc[$], expPc[$];
    int unsigned expCycles;
    logic [2:0]  expFlag;
    logic [14:0] expHaltPc;

    bit          prevReq = 1'b0;
    bit          acked = 1'b0;
    int unsigned reqLen = 0;
    int unsigned reqDelay = 0;
    logic [14:0] reqAddr;
    logic [15:0] reqOut;

    // Instruction ROM and data RAM responder; samples 1 time unit after each rising edge.
    initial begin
        instr = '0; instr_valid = 1'b0; inM = '0; mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) cyc++;
            if (reset && halted && haltCycle == 0) haltCycle = cyc;
            if (pc != lastPc) begin
                obsPc.push_back(pc);
                lastPc = pc;
            end
            instr = rom[pc[7:0]];
            instr_valid = (delayMode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            checkVal("exclusiveReq", {31'b0, mem_rd & wrtM}, 32'd0);
            if (mem_rd || wrtM) begin
                if (!prevReq) begin
                    reqAddr = addrM; reqOut = outM; reqLen = 0; acked = 1'b0;
                    reqDelay = (delayMode == 0) ? 0 : (delayMode == 2) ? 2 : $urandom_range(2);
                end else begin
                    checkVal("addrStable", {17'b0, addrM}, {17'b0, reqAddr});
                    if (wrtM) checkVal("outStable", {16'b0, outM}, {16'b0, reqOut});
                end
                reqLen++;
                if (wrtM && withholdWr) begin
                    mem_ack = 1'b0;
                end else if (reqLen > reqDelay) begin
                    mem_ack = 1'b1;
                    acked = 1'b1;
                    if (wrtM) begin
                        obsW.push_back({addrM, outM});
                        ram[addrM] = outM;
                    end else begin
                        inM = ram.exists(addrM) ? ram[addrM] : 16'h0;
                        obsR.push_back(addrM);
                    end
                end else begin
                    mem_ack = 1'b0;
                    inM = 16'($urandom);
                end
            end else begin
                if (prevReq && acked) checkVal("reqCycles", reqLen, reqDelay + 1);
                mem_ack = ackIdle ? 1'b1 : ((delayMode == 1) ? 1'($urandom_range(1)) : 1'b0);
                inM = 16'($urandom);
            end
            prevReq = mem_rd | wrtM;
        end
    end

    function automatic logic [15:0] cIns(input logic a, input logic [5:0] c,
                                         input logic [2:0] d, input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    task automatic emit(input logic [15:0] w);
        rom[wp[7:0]] = w;
        wp++;
    endtask

    task automatic emitAt(input logic [14:0] v);
        emit({1'b0, v});
    endtask

    task automatic emitHalt();
        emitAt(15'(wp + 1));
        emit(cIns(1'b0, 6'b101010, 3'b000, 3'b111));
    endtask

    task automatic clearRom();
        foreach (rom[i]) rom[i] = '0;
        wp = 0;
    endtask

    function automatic logic [15:0] memRead(input logic [14:0] k);
        return mMem.exists(k) ? mMem[k] : 16'h0;
    endfunction

    // Hack ALU from its definition: zero, bitwise negate as 0xFFFF-v, add or and, negate.
    function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        int unsigned xs, ys, r;
        xs = c[5] ? 0 : int'(x);
        if (c[4]) xs = 32'hFFFF - xs;
        ys = c[3] ? 0 : int'(y);
        if (c[2]) ys = 32'hFFFF - ys;
        r = c[1] ? ((xs + ys) % 65536) : (xs & ys);
        if (c[0]) r = 32'hFFFF - r;
        return 16'(r);
    endfunction

    task automatic runModel();
        logic [15:0] a, d, ins, y, res;
        logic [14:0] p;
        logic        ng, zr, ps, taken;
        a = '0; d = '0; p = '0;
        expCycles = 0; expFlag = 3'b010; expHaltPc = '0;
        expW.delete(); expR.delete(); expPc.delete();
        for (int unsigned step = 0; step < 5000; step++) begin
            ins = rom[p[7:0]];
            if (!ins[15]) begin
                a = {1'b0, ins[14:0]};
                p = p + 15'd1;
                expCycles += 2;
                expPc.push_back(p);
            end else begin
                if (ins[12]) begin
                    y = memRead(a[14:0]);
                    expR.push_back(a[14:0]);
                end else begin
                    y = a;
                end
                res = hackAlu(d, y, ins[11:6]);
                ng = res[15]; zr = (res == 16'h0); ps = !ng && !zr;
                expFlag = {ng, zr, ps};
                expCycles += 3 + int'(ins[12]) + int'(ins[3]);
                taken = |(ins[2:0] & {ng, zr, ps});
                if (taken && a[14:0] == p && ins[5:3] == 3'b000) begin
                    expHaltPc = p;
                    break;
                end
                if (ins[3]) begin
                    expW.push_back({a[14:0], res});
                    mMem[a[14:0]] = res;
                end
                p = taken ? a[14:0] : p + 15'd1;
                if (ins[5]) a = res;
                if (ins[4]) d = res;
                expPc.push_back(p);
            end
        end
    endtask

    task automatic genRandom();
        int unsigned nItems;
        int unsigned kind  [32];
        int unsigned start [33];
        clearRom();
        nItems = $urandom_range(18, 6);
        for (int unsigned i = 0; i < nItems; i++) begin
            start[i] = wp;
            kind[i]  = $urandom_range(3);
            wp += (kind[i] == 2) ? 2 : 1;
        end
        start[nItems] = wp;
        for (int unsigned i = 0; i < nItems; i++) begin
            wp = start[i];
            case (kind[i])
                0: emitAt(($urandom_range(3) == 0) ? 15'($urandom) : 15'($urandom_range(15)));
                2: begin
                    emitAt(15'(start[$urandom_range(nItems, i + 1)]));
                    emit(cIns(1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom_range(7, 1))));
                end
                default: emit(cIns(1'($urandom), 6'($urandom), 3'($urandom), 3'b000));
            endcase
        end
        wp = start[nItems];
        emitHalt();
    endtask

    task automatic runProgram(input int mode, input string name);
        logic [15:0] v;
        reset = 1'b0;
        delayMode = mode;
        withholdWr = 1'b0;
        @(negedge clk);
        obsW.delete(); obsR.delete(); obsPc.delete();
        ram.delete(); mMem.delete();
        for (int unsigned i = 0; i < 16; i++) begin
            v = 16'($urandom);
            ram[15'(i)] = v;
            mMem[15'(i)] = v;
        end
        lastPc = '0; cyc = 0; haltCycle = 0;
        runModel();
        @(negedge clk);
        reset = 1'b1;
        for (int unsigned t = 0; t < 3000 && haltCycle == 0; t++) @(negedge clk);
        checkVal({name, " halted"}, {31'b0, halted}, 32'd1);
        if (mode == 0) checkVal({name, " cycles"}, haltCycle, expCycles);
        checkVal({name, " haltPc"}, {17'b0, pc}, {17'b0, expHaltPc});
        checkVal({name, " flagM"}, {29'b0, flagM}, {29'b0, expFlag});
        repeat (4) begin
            @(negedge clk);
            checkVal({name, " idleAfterHalt"}, {31'b0, mem_rd | wrtM}, 32'd0);
        end
        checkVal({name, " pcHeld"}, {17'b0, pc}, {17'b0, expHaltPc});
        checkVal({name, " nWrites"}, obsW.size(), expW.size());
        foreach (expW[i]) if (i < obsW.size()) checkVal({name, " write"}, {1'b0, obsW[i]}, {1'b0, expW[i]});
        checkVal({name, " nReads"}, obsR.size(), expR.size());
        foreach (expR[i]) if (i < obsR.size()) checkVal({name, " readAddr"}, {17'b0, obsR[i]}, {17'b0, expR[i]});
        checkVal({name, " nPcSteps"}, obsPc.size(), expPc.size());
        foreach (expPc[i]) if (i < obsPc.size()) checkVal({name, " pcTrace"}, {17'b0, obsPc[i]}, {17'b0, expPc[i]});
    endtask

    initial begin
        reset = 1'b0;
        reset24 = 1'b0;
        tailJump24 = 1'b1;
        clearRom();
        repeat (2) @(negedge clk);

        checkVal("resetPc", {17'b0, pc}, 32'd0);
        checkVal("resetFlag", {29'b0, flagM}, 32'b010);
        checkVal("resetOutM", {16'b0, outM}, 32'd0);
        checkVal("resetReq", {30'b0, mem_rd, wrtM}, 32'd0);
        checkVal("resetHalted", {31'b0, halted}, 32'd0);

        // @5; D=A; @7; M=D
        clearRom();
        emitAt(15'd5); emit(cIns(1'b0, 6'b110000, 3'b010, 3'b000));
        emitAt(15'd7); emit(cIns(1'b0, 6'b001100, 3'b001, 3'b000));
        emitHalt();
        runProgram(0, "storeD");

        // @3; D=A; @3; D=D+A; @10; M=D with 2-cycle write waits
        clearRom();
        emitAt(15'd3); emit(cIns(1'b0, 6'b110000, 3'b010, 3'b000));
        emitAt(15'd3); emit(cIns(1'b0, 6'b000010, 3'b010, 3'b000));
        emitAt(15'd10); emit(cIns(1'b0, 6'b001100, 3'b001, 3'b000));
        emitHalt();
        runProgram(2, "slowWrite");

        // @9; M=-1; @9; D=M; D;JLT forward to the halt loop
        clearRom();
        emitAt(15'd9); emit(cIns(1'b0, 6'b111010, 3'b001, 3'b000));
        emitAt(15'd9); emit(cIns(1'b1, 6'b110000, 3'b010, 3'b000));
        emitAt(15'(wp + 2)); emit(cIns(1'b0, 6'b001100, 3'b000, 3'b100));
        emitHalt();
        runProgram(1, "readJlt");

        // @4; AM=A+1
        clearRom();
        emitAt(15'd4); emit(cIns(1'b0, 6'b110111, 3'b101, 3'b000));
        emitHalt();
        runProgram(0, "amInc");

        // Reset in the middle of a withheld write, then a late ack while restarting.
        clearRom();
        emitAt(15'd7); emit(cIns(1'b0, 6'b011111, 3'b001, 3'b000));
        emitHalt();
        reset = 1'b0; delayMode = 0; withholdWr = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int unsigned t = 0; t < 50 && !wrtM; t++) @(negedge clk);
        checkVal("wrtMRaised", {31'b0, wrtM}, 32'd1);
        checkVal("wrtOutM", {16'b0, outM}, 32'd1);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkVal("abortWrtM", {31'b0, wrtM}, 32'd0);
        checkVal("abortMemRd", {31'b0, mem_rd}, 32'd0);
        checkVal("abortPc", {17'b0, pc}, 32'd0);
        checkVal("abortAddrM", {17'b0, addrM}, 32'd0);
        checkVal("abortOutM", {16'b0, outM}, 32'd0);
        checkVal("abortFlag", {29'b0, flagM}, 32'b010);
        ackIdle = 1'b1;
        runProgram(0, "afterAbort");
        ackIdle = 1'b0;

        for (int unsigned n = 0; n < 24; n++) begin
            genRandom();
            runProgram(int'(n % 2), $sformatf("rand%0d", n));
        end

        // 24-bit core: jump to 0xFFFFF then halt on a jump-to-self there.
        @(negedge clk);
        reset24 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkVal("w24Halted", {31'b0, halted24}, 32'd1);
        checkVal("w24HaltPc", {12'b0, pc24}, 32'hFFFFF);
        repeat (6) @(posedge clk);
        #1;
        checkVal("w24Idle", {30'b0, memRd24, wrtM24}, 32'd0);
        checkVal("w24PcHeld", {12'b0, pc24}, 32'hFFFFF);

        // 24-bit core: a non-jump at 0xFFFFF wraps pc to 0.
        reset24 = 1'b0;
        tailJump24 = 1'b0;
        @(negedge clk);
        reset24 = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checkVal("w24PreWrap", {12'b0, pc24}, 32'hFFFFF);
        @(posedge clk);
        #1;
        checkVal("w24Wrap", {12'b0, pc24}, 32'd0);
        checkVal("w24NotHalted", {31'b0, halted24}, 32'd0);
        checkVal("w24OutM", {8'b0, outM24}, 32'h0FFFFF);
        checkVal("w24Flag", {29'b0, flagM24}, 32'b001);
        checkVal("w24AddrM", {12'b0, addrM24}, 32'hFFFFF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
